// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory-port arbiter.
//   arb_state_e : arbiter FSM states
//   owner_e     : which requester owns the current transfer
//   line_off_w  : byte-offset width of an I-side refill line
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_CMD  = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  localparam int LINE_BEATS_DFLT = 4;

  // Number of low address bits covered by one refill line of 32-bit beats.
  function automatic int line_off_w(input int beats);
    return $clog2(beats * 4);
  endfunction

  localparam int LINE_OFF_W = line_off_w(LINE_BEATS_DFLT);

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker.
//   clk, rst_n : clock, asynchronous active-low reset
//   req_i[1:0] : requests, bit 0 = I-side, bit 1 = D-side
//   upd_i      : when high and a winner exists, that winner becomes last-winner
//   gnt_o[1:0] : one-hot winner (combinational), zero when no request
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  output logic [1:0] gnt_o
);

  owner_e last_q, last_d;

  always_comb begin
    gnt_o = 2'b00;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      // Tie goes to the side that did not win most recently.
      2'b11:   gnt_o = (last_q == OWN_I) ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (upd_i && (gnt_o != 2'b00)) last_d = gnt_o[1] ? OWN_D : OWN_I;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= OWN_I;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory interface between the I-side refill path
// (read-only, LINE_BEATS-beat bursts) and the D-side access path (single-word
// read/write). One transfer at a time, round-robin between the two sides.
//   i_req/i_addr -> i_gnt, i_rvalid, i_rdata, i_last    : I-side refill
//   d_req/d_we/d_addr/d_wdata -> d_gnt, d_rvalid, d_rdata, d_wack : D-side
//   m_req/m_we/m_burst/m_addr/m_wdata, m_ready, m_rvalid/m_rdata   : memory
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_BEATS = LINE_BEATS_DFLT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_last,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_wack,
  output logic              m_req,
  output logic              m_we,
  output logic              m_burst,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ready,
  input  logic              m_rvalid,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam int OFF_W = line_off_w(LINE_BEATS);
  localparam int CNT_W = $clog2(LINE_BEATS);
  localparam logic [ADDR_W-1:0] I_MASK = {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};
  localparam logic [ADDR_W-1:0] D_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(LINE_BEATS - 1);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic              gnt_q, gnt_d;
  logic              wack_q, wack_d;
  logic              irv_q, irv_d;
  logic              drv_q, drv_d;
  logic              ilast_q, ilast_d;
  logic              latch_en;
  logic              final_beat;
  logic [1:0]        win;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  // Arbitration only matters in IDLE; the last-winner updates on the leaving edge.
  rr_arb2 u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i ({d_req, i_req}),
    .upd_i (state_q == ARB_IDLE),
    .gnt_o (win)
  );

  assign final_beat = (owner_q == OWN_D) || (cnt_q == CNT_MAX);

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    gnt_d    = 1'b0;
    wack_d   = 1'b0;
    irv_d    = 1'b0;
    drv_d    = 1'b0;
    ilast_d  = 1'b0;
    latch_en = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (win != 2'b00) begin
          state_d  = ARB_CMD;
          owner_d  = win[1] ? OWN_D : OWN_I;
          we_d     = win[1] & d_we;
          gnt_d    = 1'b1;
          latch_en = 1'b1;
        end
      end
      ARB_CMD: begin
        if (m_ready) begin
          cnt_d = '0;
          if (we_q) begin
            state_d = ARB_IDLE;
            wack_d  = 1'b1;
          end else begin
            state_d = ARB_DATA;
          end
        end
      end
      ARB_DATA: begin
        if (m_rvalid) begin
          irv_d   = (owner_q == OWN_I);
          drv_d   = (owner_q == OWN_D);
          ilast_d = (owner_q == OWN_I) && final_beat;
          cnt_d   = final_beat ? '0 : cnt_q + CNT_W'(1);
          if (final_beat) state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      owner_q <= OWN_I;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      gnt_q   <= 1'b0;
      wack_q  <= 1'b0;
      irv_q   <= 1'b0;
      drv_q   <= 1'b0;
      ilast_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      gnt_q   <= gnt_d;
      wack_q  <= wack_d;
      irv_q   <= irv_d;
      drv_q   <= drv_d;
      ilast_q <= ilast_d;
    end
  end

  // Command/data payload registers; outputs are gated by control state, so
  // they need no reset.
  always_ff @(posedge clk) begin
    if (latch_en) begin
      addr_q  <= win[1] ? (d_addr & D_MASK) : (i_addr & I_MASK);
      wdata_q <= d_wdata;
    end
    if ((state_q == ARB_DATA) && m_rvalid) rdata_q <= m_rdata;
  end

  assign m_req    = (state_q == ARB_CMD);
  assign m_we     = m_req & we_q;
  assign m_burst  = m_req & (owner_q == OWN_I);
  assign m_addr   = m_req ? addr_q : '0;
  assign m_wdata  = m_we ? wdata_q : '0;

  assign i_gnt    = gnt_q & (owner_q == OWN_I);
  assign d_gnt    = gnt_q & (owner_q == OWN_D);
  assign i_rvalid = irv_q;
  assign i_rdata  = irv_q ? rdata_q : '0;
  assign i_last   = ilast_q;
  assign d_rvalid = drv_q;
  assign d_rdata  = drv_q ? rdata_q : '0;
  assign d_wack   = wack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt, i_rvalid, i_last;
  logic [31:0] i_rdata;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt, d_rvalid, d_wack;
  logic [31:0] d_rdata;
  logic        m_req, m_we, m_burst;
  logic [31:0] m_addr, m_wdata;
  logic        m_ready, m_rvalid;
  logic [31:0] m_rdata;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LINE_BEATS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .i_rdata(i_rdata), .i_last(i_last),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_wack(d_wack),
    .m_req(m_req), .m_we(m_we), .m_burst(m_burst), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] ctl_vec;
    return {i_gnt, i_rvalid, i_last, d_gnt, d_rvalid, d_wack, m_req, m_we, m_burst};
  endfunction

  task automatic test_reset;
    rst_n = 1'b0; i_req = 1'b1; d_req = 1'b1; i_addr = 32'h40; d_we = 1'b1;
    d_addr = 32'h80; d_wdata = 32'h1234; m_ready = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h99;
    tick; tick;
    checks++; if (ctl_vec() !== 9'b0) begin errors++; $display("FAIL reset_ctl: got %b exp %b", ctl_vec(), 9'b0); end
    checks++; if ({m_addr, m_wdata, i_rdata, d_rdata} !== 128'b0) begin errors++; $display("FAIL reset_data: got %h exp 0", {m_addr, m_wdata, i_rdata, d_rdata}); end
    i_req = 1'b0; d_req = 1'b0; m_ready = 1'b0; m_rvalid = 1'b0;
    rst_n = 1'b1;
    tick;
    checks++; if (ctl_vec() !== 9'b0) begin errors++; $display("FAIL post_reset_idle: got %b exp %b", ctl_vec(), 9'b0); end
  endtask

  task automatic test_arbitration;
    logic [1:0] exp_order [3] = '{2'b10, 2'b01, 2'b10};
    logic [1:0] got;
    i_addr = 32'h0000_0104; d_we = 1'b1; d_addr = 32'h3000_0000; d_wdata = 32'h11;
    i_req = 1'b1; d_req = 1'b1;
    for (int t = 0; t < 3; t++) begin
      int n = 0;
      got = 2'b00;
      while (got == 2'b00 && n < 10) begin tick; n++; got = {d_gnt, i_gnt}; end
      checks++; if (got !== exp_order[t]) begin errors++; $display("FAIL arb_order_%0d: got {d,i}=%b exp %b", t, got, exp_order[t]); end
      if (t == 2) begin i_req = 1'b0; d_req = 1'b0; end
      m_ready = 1'b1; tick; m_ready = 1'b0;
      if (got == 2'b01) begin
        for (int b = 0; b < 4; b++) begin m_rvalid = 1'b1; m_rdata = 32'(b); tick; end
        m_rvalid = 1'b0;
      end
    end
    tick; tick;
    checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL arb_idle_after: got %b exp 0", m_req); end
  endtask

  task automatic test_i_refill;
    i_addr = 32'h0040_0014; i_req = 1'b1;
    tick;
    checks++; if ({i_gnt, d_gnt, m_req, m_burst, m_we} !== 5'b10110) begin errors++; $display("FAIL irefill_cmd: got %b exp %b", {i_gnt, d_gnt, m_req, m_burst, m_we}, 5'b10110); end
    checks++; if (m_addr !== 32'h0040_0010) begin errors++; $display("FAIL irefill_addr: got %h exp %h", m_addr, 32'h0040_0010); end
    i_req = 1'b0; m_ready = 1'b1;
    tick;
    m_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      m_rvalid = 1'b0; tick;
      checks++; if ({i_rvalid, d_rvalid} !== 2'b00) begin errors++; $display("FAIL irefill_gap_%0d: got %b exp 00", b, {i_rvalid, d_rvalid}); end
      m_rvalid = 1'b1; m_rdata = 32'hA0 + 32'(b); tick;
      m_rvalid = 1'b0;
      checks++; if ({i_rvalid, i_last, d_rvalid} !== {1'b1, (b == 3), 1'b0}) begin errors++; $display("FAIL irefill_beat_%0d: got rv/last/drv %b exp %b", b, {i_rvalid, i_last, d_rvalid}, {1'b1, (b == 3), 1'b0}); end
      checks++; if (i_rdata !== 32'hA0 + 32'(b)) begin errors++; $display("FAIL irefill_data_%0d: got %h exp %h", b, i_rdata, 32'hA0 + 32'(b)); end
    end
    tick;
    checks++; if (ctl_vec() !== 9'b0) begin errors++; $display("FAIL irefill_idle: got %b exp 0", ctl_vec()); end
  endtask

  task automatic test_d_write;
    d_we = 1'b1; d_addr = 32'h1000_0006; d_wdata = 32'hDEAD_BEEF; d_req = 1'b1;
    tick;
    checks++; if ({d_gnt, i_gnt, m_req, m_we, m_burst} !== 5'b10110) begin errors++; $display("FAIL dwr_cmd: got %b exp %b", {d_gnt, i_gnt, m_req, m_we, m_burst}, 5'b10110); end
    d_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) tick;
      checks++; if ({m_req, m_addr, m_wdata} !== {1'b1, 32'h1000_0004, 32'hDEAD_BEEF}) begin errors++; $display("FAIL dwr_hold_%0d: got req=%b addr=%h wdata=%h exp 1 10000004 deadbeef", c, m_req, m_addr, m_wdata); end
      checks++; if ({d_gnt, d_wack} !== 2'b00 && c > 0) begin errors++; $display("FAIL dwr_nognt_%0d: got %b exp 00", c, {d_gnt, d_wack}); end
    end
    m_ready = 1'b1; tick; m_ready = 1'b0;
    checks++; if ({d_wack, m_req} !== 2'b10) begin errors++; $display("FAIL dwr_wack: got wack/mreq %b exp 10", {d_wack, m_req}); end
    tick;
    checks++; if (d_wack !== 1'b0) begin errors++; $display("FAIL dwr_wack_pulse: got %b exp 0", d_wack); end
  endtask

  task automatic test_stray_rvalid;
    m_rvalid = 1'b1; m_rdata = 32'hBAD;
    tick; tick;
    checks++; if ({i_rvalid, d_rvalid} !== 2'b00) begin errors++; $display("FAIL stray_idle: got %b exp 00", {i_rvalid, d_rvalid}); end
    d_we = 1'b0; d_addr = 32'h0000_0200; d_req = 1'b1;
    tick;
    d_req = 1'b0;
    tick;
    checks++; if ({m_req, i_rvalid, d_rvalid} !== 3'b100) begin errors++; $display("FAIL stray_cmd: got %b exp 100", {m_req, i_rvalid, d_rvalid}); end
    m_rvalid = 1'b0; m_ready = 1'b1; tick; m_ready = 1'b0;
    checks++; if ({i_rvalid, d_rvalid} !== 2'b00) begin errors++; $display("FAIL stray_accept: got %b exp 00", {i_rvalid, d_rvalid}); end
    m_rvalid = 1'b1; m_rdata = 32'h55; tick; m_rvalid = 1'b0;
    checks++; if ({d_rvalid, d_rdata} !== {1'b1, 32'h55}) begin errors++; $display("FAIL stray_real_beat: got %b %h exp 1 00000055", d_rvalid, d_rdata); end
    tick;
  endtask

  task automatic test_reset_mid;
    i_addr = 32'h0000_1008; i_req = 1'b1;
    tick;
    i_req = 1'b0; m_ready = 1'b1; tick; m_ready = 1'b0;
    for (int b = 0; b < 2; b++) begin m_rvalid = 1'b1; m_rdata = 32'hC0 + 32'(b); tick; end
    m_rvalid = 1'b0;
    checks++; if ({i_rvalid, i_rdata} !== {1'b1, 32'hC1}) begin errors++; $display("FAIL rstmid_beat1: got %b %h exp 1 000000c1", i_rvalid, i_rdata); end
    rst_n = 1'b0; #1;
    checks++; if ({ctl_vec(), i_rdata} !== 41'b0) begin errors++; $display("FAIL rstmid_immediate: got %b %h exp 0", ctl_vec(), i_rdata); end
    tick;
    rst_n = 1'b1;
    for (int b = 2; b < 4; b++) begin
      m_rvalid = 1'b1; m_rdata = 32'hC0 + 32'(b); tick;
      checks++; if ({i_rvalid, i_last, d_rvalid} !== 3'b000) begin errors++; $display("FAIL rstmid_late_%0d: got %b exp 000", b, {i_rvalid, i_last, d_rvalid}); end
    end
    m_rvalid = 1'b0;
    i_addr = 32'h0000_2030; i_req = 1'b1;
    tick;
    checks++; if ({i_gnt, m_req, m_addr} !== {2'b11, 32'h0000_2030}) begin errors++; $display("FAIL rstmid_regrant: got %b %b %h exp 1 1 00002030", i_gnt, m_req, m_addr); end
    i_req = 1'b0; m_ready = 1'b1; tick; m_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin m_rvalid = 1'b1; m_rdata = 32'hE0 + 32'(b); tick; end
    m_rvalid = 1'b0;
    checks++; if ({i_rvalid, i_last, i_rdata} !== {2'b11, 32'hE3}) begin errors++; $display("FAIL rstmid_refill_last: got %b %b %h exp 1 1 000000e3", i_rvalid, i_last, i_rdata); end
    tick;
  endtask

  task automatic test_d_read_fast;
    d_we = 1'b0; d_addr = 32'h2000_000B; d_req = 1'b1;
    tick;
    checks++; if ({d_gnt, m_req, m_we, m_burst, m_addr} !== {4'b1100, 32'h2000_0008}) begin errors++; $display("FAIL drd_cmd: got %b%b%b%b %h exp 1100 20000008", d_gnt, m_req, m_we, m_burst, m_addr); end
    d_req = 1'b0; m_ready = 1'b1;
    tick;
    m_ready = 1'b0;
    checks++; if ({m_req, d_rvalid} !== 2'b00) begin errors++; $display("FAIL drd_accept: got %b exp 00", {m_req, d_rvalid}); end
    m_rvalid = 1'b1; m_rdata = 32'h1234_5678;
    #3;
    checks++; if (d_rvalid !== 1'b0) begin errors++; $display("FAIL drd_not_early: got %b exp 0", d_rvalid); end
    tick;
    m_rvalid = 1'b0;
    checks++; if ({d_rvalid, d_rdata, i_rvalid} !== {1'b1, 32'h1234_5678, 1'b0}) begin errors++; $display("FAIL drd_data: got %b %h %b exp 1 12345678 0", d_rvalid, d_rdata, i_rvalid); end
    tick;
    checks++; if ({d_rvalid, m_req} !== 2'b00) begin errors++; $display("FAIL drd_done: got %b exp 00", {d_rvalid, m_req}); end
  endtask

  initial begin
    test_reset();
    test_arbitration();
    test_i_refill();
    test_d_write();
    test_stray_rvalid();
    test_reset_mid();
    test_d_read_fast();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
